prog_tick_gen: RTL and testbench

PROG_TICK_GEN -- requirements
Module: prog_tick_gen

---
 rtl/prog_tick_gen.sv | 97 +++++++++
 tb/tb_prog_tick_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_tick_gen.sv
// Programmable tick generator: divides clk by a run-time divisor, producing a
// one-cycle tick, a matching square wave and a wrapping tick counter.
module prog_tick_gen #(
  parameter int WIDTH       = 27,
  parameter int DEFAULT_DIV = 100000000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             sq,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             div_err,
  output logic [WIDTH-1:0] div_act
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_act;
  logic [WIDTH-1:0] r_pend_val;
  logic             r_pend;
  logic             r_sq;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             r_err;

  logic             w_term;
  logic             w_tc;
  logic             w_load_ok;
  logic             w_load_bad;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_half;

  always_comb begin
    w_term     = (r_cnt == (r_div_act - ONE));
    // Reset masks the terminal count so no tick escapes during reset.
    w_tc       = w_term & en & ~reset;
    w_load_ok  = div_load & (div_in >= MIN_DIV);
    w_load_bad = div_load & (div_in <  MIN_DIV);
    w_cnt_inc  = r_cnt + ONE;
    w_half     = r_div_act >> 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_sq       <= 1'b0;
      r_tick_cnt <= '0;
      r_div_act  <= RST_DIV;
      r_pend_val <= RST_DIV;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_load_bad;
      if (w_tc) begin
        // A load arriving on the wrap cycle takes effect at this same wrap.
        r_cnt      <= '0;
        r_sq       <= 1'b0;
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        r_pend     <= 1'b0;
        if (w_load_ok) begin
          r_div_act <= div_in;
        end else if (r_pend) begin
          r_div_act <= r_pend_val;
        end
      end else if (en) begin
        r_cnt <= w_cnt_inc;
        r_sq  <= (w_cnt_inc >= w_half);
        if (w_load_ok) begin
          r_pend_val <= div_in;
          r_pend     <= 1'b1;
        end
      end else if (r_pend) begin
        // Paused with a divisor waiting: nothing to glitch, so apply now.
        r_cnt     <= '0;
        r_sq      <= 1'b0;
        r_pend    <= 1'b0;
        r_div_act <= w_load_ok ? div_in : r_pend_val;
      end else if (w_load_ok) begin
        r_pend_val <= div_in;
        r_pend     <= 1'b1;
      end
    end
  end

  assign tick     = w_tc;
  assign sq       = r_sq;
  assign tick_cnt = r_tick_cnt;
  assign div_err  = r_err;
  assign div_act  = r_div_act;

endmodule

// File: tb/tb_prog_tick_gen.sv
// Directed bench for prog_tick_gen with DEFAULT_DIV=10, WIDTH=8, CNT_W=4.
module tb_prog_tick_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic       div_load;
  logic [7:0] div_in;
  logic       tick;
  logic       sq;
  logic [3:0] tick_cnt;
  logic       div_err;
  logic [7:0] div_act;

  int checks = 0;
  int errors = 0;
  int tq[$];
  logic sq_log[$];

  prog_tick_gen #(.WIDTH(8), .DEFAULT_DIV(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .div_load(div_load), .div_in(div_in),
    .tick(tick), .sq(sq), .tick_cnt(tick_cnt), .div_err(div_err), .div_act(div_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs n cycles with current inputs; logs 1-based cycle numbers of ticks and sq per cycle.
  task automatic run(input int n);
    tq.delete();
    sq_log.delete();
    for (int k = 1; k <= n; k++) begin
      #1;
      if (tick) tq.push_back(k);
      sq_log.push_back(sq);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; div_load = 1'b0; div_in = 8'd0;
    @(posedge clk);
    #1;
    div_load = 1'b1; div_in = 8'd5;
    #1;
    chk("reset_tick", int'(tick), 0);
    @(posedge clk);
    #1;
    chk("reset_sq", int'(sq), 0);
    chk("reset_tick_cnt", int'(tick_cnt), 0);
    chk("reset_div_act", int'(div_act), 10);
    chk("reset_div_err", int'(div_err), 0);

    // Basic division
    reset = 1'b0; div_load = 1'b0;
    run(35);
    chk("basic_nticks", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("basic_t0", tq[0], 10);
      chk("basic_t1", tq[1], 20);
      chk("basic_t2", tq[2], 30);
    end
    chk("basic_sq_c5", int'(sq_log[4]), 0);
    chk("basic_sq_c6", int'(sq_log[5]), 1);
    chk("basic_sq_c10", int'(sq_log[9]), 1);
    chk("basic_sq_c11", int'(sq_log[10]), 0);
    chk("basic_tick_cnt", int'(tick_cnt), 3);

    // Mid-period load, back-to-back: 7 then 4, only 4 survives
    do_reset();
    run(3);
    div_load = 1'b1; div_in = 8'd7;
    run(1);
    div_in = 8'd4;
    run(1);
    chk("load_pending_div_act", int'(div_act), 10);
    div_load = 1'b0; div_in = 8'd1;
    run(13);
    chk("load_nticks", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("load_t0", tq[0], 5);
      chk("load_t1", tq[1], 9);
      chk("load_t2", tq[2], 13);
    end
    chk("load_div_act", int'(div_act), 4);
    chk("ignored_div_in_err", int'(div_err), 0);

    // Rejected load
    do_reset();
    run(2);
    div_load = 1'b1; div_in = 8'd1;
    run(1);
    div_load = 1'b0; div_in = 8'd0;
    chk("rej_err_hi", int'(div_err), 1);
    run(1);
    chk("rej_err_lo", int'(div_err), 0);
    chk("rej_div_act", int'(div_act), 10);
    run(16);
    chk("rej_nticks", tq.size(), 2);
    if (tq.size() == 2) begin
      chk("rej_t0", tq[0], 6);
      chk("rej_t1", tq[1], 16);
    end
    chk("rej_div_act_after", int'(div_act), 10);

    // Enable pause at cnt=6
    run(6);
    en = 1'b0;
    run(7);
    chk("pause_nticks", tq.size(), 0);
    chk("pause_sq_first", int'(sq_log[0]), 1);
    chk("pause_sq_last", int'(sq_log[6]), 1);
    chk("pause_tick_cnt", int'(tick_cnt), 2);
    en = 1'b1;
    run(4);
    chk("resume_nticks", tq.size(), 1);
    if (tq.size() == 1) chk("resume_t0", tq[0], 4);
    chk("resume_tick_cnt", int'(tick_cnt), 3);

    // Odd divisor 3 loaded while paused, tick_cnt wrap
    do_reset();
    en = 1'b0; div_load = 1'b1; div_in = 8'd3;
    run(1);
    div_load = 1'b0;
    run(1);
    chk("odd_div_act", int'(div_act), 3);
    en = 1'b1;
    run(45);
    chk("odd_nticks", tq.size(), 15);
    chk("odd_tick_cnt_15", int'(tick_cnt), 15);
    chk("odd_sq_c1", int'(sq_log[0]), 0);
    chk("odd_sq_c2", int'(sq_log[1]), 1);
    chk("odd_sq_c3", int'(sq_log[2]), 1);
    chk("odd_sq_c4", int'(sq_log[3]), 0);
    run(3);
    chk("odd_tick_cnt_wrap", int'(tick_cnt), 0);
    run(12);
    chk("odd_tick_cnt_4", int'(tick_cnt), 4);

    // Reset coincident with TC and a pending divisor of 5
    do_reset();
    run(2);
    div_load = 1'b1; div_in = 8'd5;
    run(1);
    div_load = 1'b0;
    run(6);
    reset = 1'b1;
    #1;
    chk("rstpri_tick", int'(tick), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstpri_tick_cnt", int'(tick_cnt), 0);
    chk("rstpri_div_act", int'(div_act), 10);
    chk("rstpri_sq", int'(sq), 0);
    run(10);
    chk("rstpri_nticks", tq.size(), 1);
    if (tq.size() == 1) chk("rstpri_t0", tq[0], 10);
    chk("rstpri_pend_cleared", int'(div_act), 10);

    // Divisor 2, then a load coincident with TC
    do_reset();
    en = 1'b0; div_load = 1'b1; div_in = 8'd2;
    run(1);
    div_load = 1'b0;
    run(1);
    en = 1'b1;
    run(6);
    chk("div2_nticks", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("div2_t0", tq[0], 2);
      chk("div2_t2", tq[2], 6);
    end
    chk("div2_sq_c1", int'(sq_log[0]), 0);
    chk("div2_sq_c2", int'(sq_log[1]), 1);
    chk("div2_sq_c3", int'(sq_log[2]), 0);
    run(1);
    div_load = 1'b1; div_in = 8'd5;
    run(1);
    div_load = 1'b0;
    chk("tcload_div_act", int'(div_act), 5);
    run(5);
    chk("tcload_nticks", tq.size(), 1);
    if (tq.size() == 1) chk("tcload_t0", tq[0], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
